// File: rtl/seg7_scan_display.sv
// Multiplexed N-digit common-anode seven-segment driver with a sequential
// double-dabble binary-to-BCD converter, leading-zero blanking and overflow dashes.
module seg7_scan_display #(
   parameter int DIGITS      = 8,
   parameter int VAL_W       = 27,
   parameter int REFRESH_DIV = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [VAL_W-1:0]  value,
   input  logic              load,
   input  logic [DIGITS-1:0] dp_mask,
   input  logic              blank_lz,
   input  logic              enable,
   output logic [7:0]        CA,
   output logic [DIGITS-1:0] AN,
   output logic              busy,
   output logic              done,
   output logic              overflow
);

   localparam int BCD_W = DIGITS * 4;
   localparam int CNT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PRE_W = $clog2(REFRESH_DIV);

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

   localparam logic [63:0] LIMIT = pow10(DIGITS);

   function automatic logic [7:0] glyph(input logic [3:0] d);
      logic [7:0] g;
      case (d)
         4'd0:    g = 8'hC0;
         4'd1:    g = 8'hF9;
         4'd2:    g = 8'hA4;
         4'd3:    g = 8'hB0;
         4'd4:    g = 8'h99;
         4'd5:    g = 8'h92;
         4'd6:    g = 8'h82;
         4'd7:    g = 8'hF8;
         4'd8:    g = 8'h80;
         4'd9:    g = 8'h98;
         default: g = 8'hFF;
      endcase
      return g;
   endfunction

   // Shift-add-3 correction applied to every BCD nibble before each shift.
   function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? (b[4*i +: 4] + 4'd3) : b[4*i +: 4];
      end
      return r;
   endfunction

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   state_t                  state_r, state_s;
   logic [VAL_W-1:0]        bin_r;
   logic [BCD_W-1:0]        bcd_r;
   logic [BCD_W-1:0]        latch_r;
   logic [CNT_W-1:0]        cnt_r;
   logic                    busy_r, done_r, ovf_r, ovf_pend_r;
   logic                    capture_s, shift_s, commit_s;
   logic [BCD_W+VAL_W-1:0]  shifted_s;

   logic [PRE_W-1:0]        presc_r;
   logic [IDX_W-1:0]        idx_r;
   logic [7:0]              ca_r, ca_s, base_s;
   logic [DIGITS-1:0]       an_r, an_s;
   logic [DIGITS-1:0]       onehot_s, lz_s;
   logic [3:0]              nib_s;
   logic                    sel_lz_s, sel_dp_s, zero_run_s, wrap_s;

   // Converter state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Converter next state and datapath strobes; a load always restarts.
   always_comb begin
      state_s   = state_r;
      capture_s = load;
      shift_s   = 1'b0;
      commit_s  = 1'b0;
      case (state_r)
         S_IDLE: begin
            state_s = load ? S_SHIFT : S_IDLE;
         end
         S_SHIFT: begin
            shift_s = !load;
            if (load) begin
               state_s = S_SHIFT;
            end else if (cnt_r == CNT_W'(VAL_W - 1)) begin
               state_s = S_COMMIT;
            end else begin
               state_s = S_SHIFT;
            end
         end
         S_COMMIT: begin
            commit_s = !load;
            state_s  = load ? S_SHIFT : S_IDLE;
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   assign shifted_s = {add3(bcd_r), bin_r} << 1;

   // Conversion datapath, display latch and status flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bin_r      <= {VAL_W{1'b0}};
         bcd_r      <= {BCD_W{1'b0}};
         latch_r    <= {BCD_W{1'b0}};
         cnt_r      <= {CNT_W{1'b0}};
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         ovf_r      <= 1'b0;
         ovf_pend_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (capture_s) begin
            bin_r      <= value;
            bcd_r      <= {BCD_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            busy_r     <= 1'b1;
            ovf_pend_r <= (64'(value) >= LIMIT);
         end else if (shift_s) begin
            {bcd_r, bin_r} <= shifted_s;
            cnt_r          <= cnt_r + CNT_W'(1);
         end else if (commit_s) begin
            latch_r <= bcd_r;
            ovf_r   <= ovf_pend_r;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
         end else begin
            busy_r <= busy_r;
         end
      end
   end

   // Digit select, leading-zero run from the top digit down, and glyph build.
   always_comb begin
      onehot_s   = {DIGITS{1'b0}};
      lz_s       = {DIGITS{1'b0}};
      nib_s      = 4'd0;
      sel_lz_s   = 1'b0;
      sel_dp_s   = 1'b0;
      zero_run_s = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run_s = zero_run_s & (latch_r[4*i +: 4] == 4'd0);
         lz_s[i]    = zero_run_s;
      end
      lz_s[0] = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         onehot_s[i] = (idx_r == IDX_W'(i));
         nib_s       = onehot_s[i] ? latch_r[4*i +: 4] : nib_s;
         sel_lz_s    = onehot_s[i] ? lz_s[i] : sel_lz_s;
         sel_dp_s    = onehot_s[i] ? dp_mask[i] : sel_dp_s;
      end
      if (ovf_r) begin
         base_s = 8'hBF;
      end else if (blank_lz && sel_lz_s) begin
         base_s = 8'hFF;
      end else begin
         base_s = glyph(nib_s);
      end
      ca_s = enable ? (base_s & ~{sel_dp_s, 7'b0000000}) : 8'hFF;
      an_s = enable ? ~onehot_s : {DIGITS{1'b1}};
   end

   assign wrap_s = (presc_r == PRE_W'(REFRESH_DIV - 1));

   // Refresh prescaler and scan index; CA/AN load on each slot wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_r <= {PRE_W{1'b0}};
         idx_r   <= {IDX_W{1'b0}};
         ca_r    <= 8'hFF;
         an_r    <= {DIGITS{1'b1}};
      end else if (wrap_s) begin
         presc_r <= {PRE_W{1'b0}};
         idx_r   <= (idx_r == IDX_W'(DIGITS - 1)) ? {IDX_W{1'b0}} : (idx_r + IDX_W'(1));
         ca_r    <= ca_s;
         an_r    <= an_s;
      end else begin
         presc_r <= presc_r + PRE_W'(1);
      end
   end

   assign CA       = ca_r;
   assign AN       = an_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign overflow = ovf_r;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: stimulus queues expected slot glyphs
// and done-pulse edges; a monitor compares them as the DUT presents them.
module tb_seg7_scan_display;

   localparam int DIGITS = 8;
   localparam int VAL_W  = 27;
   localparam int DIV    = 4;
   localparam int LAT    = VAL_W + 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [VAL_W-1:0]  value = '0;
   logic              load = 1'b0;
   logic [DIGITS-1:0] dp_mask = '0;
   logic              blank_lz = 1'b0;
   logic              enable = 1'b1;
   logic [7:0]        CA;
   logic [DIGITS-1:0] AN;
   logic              busy, done, overflow;

   seg7_scan_display #(.DIGITS(DIGITS), .VAL_W(VAL_W), .REFRESH_DIV(DIV)) dut (
      .clk(clk), .rst(rst), .value(value), .load(load), .dp_mask(dp_mask),
      .blank_lz(blank_lz), .enable(enable), .CA(CA), .AN(AN),
      .busy(busy), .done(done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         digit;
      logic [7:0] an;
      logic [7:0] ca;
   } slot_t;

   slot_t slot_q[$];
   int    done_q[$];
   int    n_total = 0;
   int    n_pass  = 0;
   int    ecnt    = 0;
   int    cyc     = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: slot updates fall on every DIV-th edge after reset release.
   initial begin
      slot_t s;
      int    e;
      int    d;
      forever begin
         @(posedge clk);
         ecnt++;
         if (rst) cyc++;
         else cyc = 0;
         #1;
         if (rst && done === 1'b1) begin
            if (done_q.size() > 0) begin
               e = done_q.pop_front();
               chk("done_edge", ecnt, e);
            end else begin
               chk("unexpected_done", done, 1'b0);
            end
         end
         if (rst && cyc > 0 && (cyc % DIV) == 0 && slot_q.size() > 0) begin
            d = ((cyc / DIV) - 1) % DIGITS;
            if (slot_q[0].digit == d) begin
               s = slot_q.pop_front();
               chk($sformatf("slot%0d_AN", d), AN, s.an);
               chk($sformatf("slot%0d_CA", d), CA, s.ca);
            end
         end
      end
   end

   task automatic do_load(input logic [VAL_W-1:0] v, input bit expect_done);
      @(negedge clk);
      value = v;
      load  = 1'b1;
      if (expect_done) done_q.push_back(ecnt + 1 + LAT);
      @(negedge clk);
      load = 1'b0;
      chk("busy_after_load", busy, 1'b1);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 100 && done_q.size() > 0; i++) @(negedge clk);
      if (done_q.size() > 0) begin
         chk("done_timeout", done_q.size(), 0);
         done_q.delete();
      end
   endtask

   task automatic show(input logic [63:0] cas, input bit en);
      slot_t s;
      for (int i = 0; i < DIGITS; i++) begin
         s.digit = i;
         s.an    = en ? ~(8'h01 << i) : 8'hFF;
         s.ca    = cas[8*i +: 8];
         slot_q.push_back(s);
      end
      for (int i = 0; i < 12 * DIGITS * DIV && slot_q.size() > 0; i++) @(negedge clk);
      if (slot_q.size() > 0) begin
         chk("slot_timeout", slot_q.size(), 0);
         slot_q.delete();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #2 rst = 1'b0;
      #1;
      chk("reset_AN", AN, 8'hFF);
      chk("reset_CA", CA, 8'hFF);
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_overflow", overflow, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      show(64'hC0C0C0C0C0C0C0C0, 1'b1);

      do_load(27'd12345678, 1'b1);
      wait_done();
      chk("busy_after_done", busy, 1'b0);
      chk("ovf_12345678", overflow, 1'b0);
      show(64'hF9A4B0999282F880, 1'b1);

      dp_mask = 8'h04;
      show(64'hF9A4B0999202F880, 1'b1);
      dp_mask = 8'h00;

      enable = 1'b0;
      show(64'hFFFFFFFFFFFFFFFF, 1'b0);
      enable = 1'b1;

      blank_lz = 1'b1;
      dp_mask  = 8'h20;
      do_load(27'd42, 1'b1);
      wait_done();
      show(64'hFFFF7FFFFFFF99A4, 1'b1);
      dp_mask = 8'h00;

      do_load(27'd0, 1'b1);
      wait_done();
      show(64'hFFFFFFFFFFFFFFC0, 1'b1);

      dp_mask = 8'h01;
      do_load(27'd100000000, 1'b1);
      wait_done();
      chk("ovf_set", overflow, 1'b1);
      show(64'hBFBFBFBFBFBFBF3F, 1'b1);
      dp_mask = 8'h00;

      do_load(27'd7, 1'b1);
      wait_done();
      chk("ovf_clear", overflow, 1'b0);
      show(64'hFFFFFFFFFFFFFFF8, 1'b1);

      do_load(27'd5, 1'b0);
      repeat (4) @(negedge clk);
      do_load(27'd9, 1'b1);
      wait_done();
      show(64'hFFFFFFFFFFFFFF98, 1'b1);

      blank_lz = 1'b0;
      do_load(27'd12345678, 1'b0);
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("midrst_AN", AN, 8'hFF);
      chk("midrst_CA", CA, 8'hFF);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_done", done, 1'b0);
      chk("midrst_overflow", overflow, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (40) @(negedge clk);
      chk("post_rst_busy", busy, 1'b0);
      show(64'hC0C0C0C0C0C0C0C0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
